seven_segment_scanner: RTL and testbench

//  Output-side counterpart to the push-button input conditioning: drives a common-anode,

---
 rtl/seven_segment_scanner_if.sv | 31 +++
 rtl/seven_segment_scanner.sv | 165 ++++++++++++++++
 tb/tb_seven_segment_scanner.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_scanner_if.sv
// ============================================================================
//  Module   : seven_segment_scanner_if
//  Purpose  : Load/display bundle between a value source and the scanner.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seven_segment_scanner_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     blank_in;
    logic [DIGITS-1:0]     anode;
    logic [6:0]            seg;
    logic                  dp;
    logic                  frame_done;

    modport master (
        output load, value, dp_in, blank_in,
        input  anode, seg, dp, frame_done
    );

    modport slave (
        input  load, value, dp_in, blank_in,
        output anode, seg, dp, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/seven_segment_scanner.sv
// ============================================================================
//  Module   : seven_segment_scanner
//  Purpose  : Common-anode multiplexed 7-segment driver with blanking gaps and
//             a double-buffered display value swapped only at frame ends.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_segment_scanner #(
    parameter int DIGITS       = 4,
    parameter int CLOCK_FREQ   = 100_000_000,
    parameter int REFRESH_US   = 1000,
    parameter int BLANK_CYCLES = 100           // 1 .. TICK-1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    seven_segment_scanner_if.slave  bus
);

    localparam int c_TICK  = CLOCK_FREQ / 1_000_000 * REFRESH_US;
    localparam int c_CNT_W = $clog2(c_TICK);
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'(c_TICK - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(DIGITS - 1);

    localparam logic [0:0] c_ST_BLANK = 1'b0;
    localparam logic [0:0] c_ST_DRIVE = 1'b1;

    logic [0:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_IDX_W-1:0]  r_idx;

    logic [4*DIGITS-1:0] r_act_val;
    logic [DIGITS-1:0]   r_act_dp;
    logic [DIGITS-1:0]   r_act_blank;
    logic [4*DIGITS-1:0] r_pend_val;
    logic [DIGITS-1:0]   r_pend_dp;
    logic [DIGITS-1:0]   r_pend_blank;
    logic                r_pend_valid;

    logic [DIGITS-1:0]   r_anode;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic                r_frame_done;

    logic                w_slot_end;
    logic                w_frame_end;
    logic [3:0]          w_nibble;
    logic [DIGITS-1:0]   w_anode_nxt;
    logic [6:0]          w_seg_nxt;
    logic                w_dp_nxt;

    function automatic logic [6:0] f_decode(input logic [3:0] n);
        case (n)
            4'h0: f_decode = 7'b1000000;
            4'h1: f_decode = 7'b1111001;
            4'h2: f_decode = 7'b0100100;
            4'h3: f_decode = 7'b0110000;
            4'h4: f_decode = 7'b0011001;
            4'h5: f_decode = 7'b0010010;
            4'h6: f_decode = 7'b0000010;
            4'h7: f_decode = 7'b1111000;
            4'h8: f_decode = 7'b0000000;
            4'h9: f_decode = 7'b0010000;
            4'hA: f_decode = 7'b0001000;
            4'hB: f_decode = 7'b0000011;
            4'hC: f_decode = 7'b1000110;
            4'hD: f_decode = 7'b0100001;
            4'hE: f_decode = 7'b0000110;
            default: f_decode = 7'b0001110;
        endcase
    endfunction

    assign w_slot_end  = (r_cnt == c_CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == c_IDX_LAST);
    assign w_nibble    = r_act_val[r_idx*4 +: 4];

    // Output registers reflect the phase of the cycle being retired, so all
    // three display outputs and frame_done move together on one edge.
    always_comb begin
        w_anode_nxt = '1;
        w_seg_nxt   = 7'h7F;
        w_dp_nxt    = 1'b1;
        if (r_state == c_ST_DRIVE) begin
            w_seg_nxt = f_decode(w_nibble);
            w_dp_nxt  = ~r_act_dp[r_idx];
            for (int i = 0; i < DIGITS; i++) begin
                if ((c_IDX_W'(i) == r_idx) && !r_act_blank[i]) begin
                    w_anode_nxt[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_BLANK;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_act_val    <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_valid <= 1'b0;
            r_anode      <= '1;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;

            case (r_state)
                c_ST_BLANK: begin
                    if (r_cnt == c_BLANK_LAST) begin
                        r_state <= c_ST_DRIVE;
                    end
                end
                default: begin
                    if (w_slot_end) begin
                        r_state <= c_ST_BLANK;
                        r_idx   <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
                    end
                end
            endcase

            r_anode      <= w_anode_nxt;
            r_seg        <= w_seg_nxt;
            r_dp         <= w_dp_nxt;
            r_frame_done <= w_frame_end;

            if (bus.load) begin
                r_pend_val   <= bus.value;
                r_pend_dp    <= bus.dp_in;
                r_pend_blank <= bus.blank_in;
                r_pend_valid <= 1'b1;
            end

            // A load coinciding with the boundary bypasses the pending buffer.
            if (w_frame_end) begin
                r_pend_valid <= 1'b0;
                if (bus.load) begin
                    r_act_val   <= bus.value;
                    r_act_dp    <= bus.dp_in;
                    r_act_blank <= bus.blank_in;
                end else if (r_pend_valid) begin
                    r_act_val   <= r_pend_val;
                    r_act_dp    <= r_pend_dp;
                    r_act_blank <= r_pend_blank;
                end
            end
        end
    end

    assign bus.anode      = r_anode;
    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
// ============================================================================
//  Module   : tb_seven_segment_scanner
//  Purpose  : Directed, table-driven self-checking bench for the scanner.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_segment_scanner;

    localparam int T_TICK  = 10;
    localparam int T_BLANK = 2;

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic [3:0][6:0] seg;     // expected pattern per digit {d3,d2,d1,d0}
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;
    string tag;

    logic [3:0][6:0] e_seg;
    logic [3:0]      e_dp;
    logic [3:0]      e_blank;

    vec_t vecs[4];

    seven_segment_scanner_if #(.DIGITS(4)) bus ();

    seven_segment_scanner #(
        .DIGITS      (4),
        .CLOCK_FREQ  (1_000_000),
        .REFRESH_US  (10),
        .BLANK_CYCLES(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [15:0] v,
                         input logic [3:0] d, input logic [3:0] b);
        bus.load     = ld;
        bus.value    = v;
        bus.dp_in    = d;
        bus.blank_in = b;
    endtask

    task automatic set_exp(input logic [3:0][6:0] s, input logic [3:0] d,
                           input logic [3:0] b);
        e_seg   = s;
        e_dp    = d;
        e_blank = b;
    endtask

    task automatic check_idle(input string name);
        n_checks++;
        if ({bus.anode, bus.seg, bus.dp, bus.frame_done} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL %s: anode=%b seg=%b dp=%b fd=%b, expected anode=1111 seg=1111111 dp=1 fd=0",
                     name, bus.anode, bus.seg, bus.dp, bus.frame_done);
        end
    endtask

    // Frame position p = 0..39; p = 39 is the cycle frame_done is high.
    task automatic check_span(input int first, input int last);
        for (int p = first; p <= last; p++) begin
            int d;
            int s;
            logic [3:0] ea;
            logic [6:0] es;
            logic       ed;
            logic       ef;
            step();
            d  = p / T_TICK;
            s  = p % T_TICK;
            ea = 4'b1111;
            es = 7'h7F;
            ed = 1'b1;
            if (s >= T_BLANK) begin
                if (!e_blank[d]) ea[d] = 1'b0;
                es = e_seg[d];
                ed = ~e_dp[d];
            end
            ef = (p == 4*T_TICK - 1);
            n_checks++;
            if ({bus.anode, bus.seg, bus.dp, bus.frame_done} !== {ea, es, ed, ef}) begin
                n_err++;
                $display("FAIL %s p=%0d: anode=%b seg=%b dp=%b fd=%b, expected anode=%b seg=%b dp=%b fd=%b",
                         tag, p, bus.anode, bus.seg, bus.dp, bus.frame_done, ea, es, ed, ef);
            end
        end
    endtask

    initial begin
        #100us;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{16'hF810, 4'b0000, 4'b0000, {7'b0001110, 7'b0000000, 7'b1111001, 7'b1000000}};
        vecs[1] = '{16'h1234, 4'b0100, 4'b0001, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        vecs[2] = '{16'hABCD, 4'b1000, 4'b0000, {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}};
        vecs[3] = '{16'h5679, 4'b1111, 4'b1010, {7'b0010010, 7'b0000010, 7'b1111000, 7'b0010000}};

        drive(1'b0, 16'h0000, 4'b0000, 4'b0000);
        set_exp({4{7'b1000000}}, 4'b0000, 4'b0000);

        // Reset state, then two idle frames showing zeros
        rst = 1'b1;
        step();
        check_idle("reset0");
        step();
        check_idle("reset1");
        rst = 1'b0;
        tag = "idle";
        check_span(0, 39);
        check_span(0, 39);

        // Table: load at frame start, old frame unchanged, new frame shown next
        for (int i = 0; i < 4; i++) begin
            $sformat(tag, "vec%0d", i);
            drive(1'b1, vecs[i].value, vecs[i].dp, vecs[i].blank);
            check_span(0, 0);
            drive(1'b0, 16'h0000, 4'b0000, 4'b0000);
            check_span(1, 39);
            set_exp(vecs[i].seg, vecs[i].dp, vecs[i].blank);
            check_span(0, 39);
        end

        // Two loads mid-frame: current frame holds, only the last is shown
        tag = "midload";
        check_span(0, 11);
        drive(1'b1, 16'h1111, 4'b1111, 4'b0000);
        check_span(12, 12);
        drive(1'b0, 16'h0000, 4'b0000, 4'b0000);
        check_span(13, 25);
        drive(1'b1, 16'h0E0E, 4'b0000, 4'b0000);
        check_span(26, 26);
        drive(1'b0, 16'h0000, 4'b0000, 4'b0000);
        check_span(27, 39);
        set_exp({7'b1000000, 7'b0000110, 7'b1000000, 7'b0000110}, 4'b0000, 4'b0000);
        tag = "lastwins";
        check_span(0, 39);

        // Load exactly on the frame_done cycle goes straight to the display
        tag = "bndload";
        check_span(0, 38);
        drive(1'b1, 16'h7531, 4'b0001, 4'b0100);
        check_span(39, 39);
        drive(1'b0, 16'h0000, 4'b0000, 4'b0000);
        set_exp({7'b1111000, 7'b0010010, 7'b0110000, 7'b1111001}, 4'b0001, 4'b0100);
        check_span(0, 39);

        // Reset mid-DRIVE drops the pending load; load during reset is ignored
        tag = "prerst";
        drive(1'b1, 16'h8888, 4'b1111, 4'b0000);
        check_span(0, 0);
        drive(1'b0, 16'h0000, 4'b0000, 4'b0000);
        check_span(1, 14);
        rst = 1'b1;
        step();
        check_idle("midrst0");
        drive(1'b1, 16'h8888, 4'b1111, 4'b0000);
        step();
        check_idle("midrst1");
        drive(1'b0, 16'h0000, 4'b0000, 4'b0000);
        rst = 1'b0;
        set_exp({4{7'b1000000}}, 4'b0000, 4'b0000);
        tag = "postrst";
        check_span(0, 39);
        check_span(0, 39);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
